// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot loader: width defaults, loader states and error codes.
package cpu_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_LEN    = 3'd0,
    S_DATA   = 3'd1,
    S_CHECK  = 3'd2,
    S_RUN    = 3'd3,
    S_HALTED = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

endpackage

// File: rtl/cpu_run_watchdog.sv
// Run-cycle counter for the released CPU. It holds at 0 while clr_i is high and counts while en_i is high.
// It saturates at TIMEOUT-1 and flags expiry combinationally. No backpressure.
module cpu_run_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o,
  output logic        expired_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/cpu_boot_loader.sv
// Loads a LEN/bytes/CHK frame into instruction memory, with each write one cycle after its accept. It then runs the CPU and captures its HALT result.
// in_ready is combinational and is low while the CPU runs, after it halts, after an error, and during clear.
module cpu_boot_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  input  logic [DATA_W-1:0] cpu_result,
  output logic [DATA_W-1:0] result_q,
  output logic [15:0]       cycle_count,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [15:0]         cyc_q, cyc_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                bad_len;
  logic [15:0]         run_count;
  logic                run_expired;

  assign in_ready = (state_q inside {S_LEN, S_DATA, S_CHECK}) && !clear;
  assign accept   = in_valid && in_ready;
  assign bad_len  = (in_data == '0) || (in_data > DATA_W'(MAX_LEN));

  cpu_run_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != S_RUN),
    .en_i      (state_q == S_RUN),
    .count_o   (run_count),
    .expired_o (run_expired)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rem_d       = rem_q;
    wr_ptr_d    = wr_ptr_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    res_d       = res_q;
    cyc_d       = cyc_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_LEN: begin
        if (accept) begin
          if (bad_len) begin
            state_d = S_ERR;
            error_d = 1'b1;
            err_d   = ERR_LEN;
          end else begin
            rem_d    = LEN_W'(in_data);
            wr_ptr_d = '0;
            csum_d   = '0;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = in_data;
          csum_d      = csum_q ^ in_data;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            err_d   = ERR_CHK;
          end
        end
      end
      S_RUN: begin
        // A halt seen on the watchdog's last cycle still counts as a clean run.
        if (cpu_halt) begin
          res_d   = cpu_result;
          cyc_d   = run_count;
          done_d  = 1'b1;
          state_d = S_HALTED;
        end else if (run_expired) begin
          error_d = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = S_ERR;
        end
      end
      default: begin
      end
    endcase

    if (clear) begin
      state_d = S_LEN;
      done_d  = 1'b0;
      error_d = 1'b0;
      err_d   = ERR_NONE;
    end

    cpu_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN;
      err_q       <= ERR_NONE;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      res_q       <= '0;
      cyc_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rem_q       <= rem_d;
      wr_ptr_q    <= wr_ptr_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      res_q       <= res_d;
      cyc_q       <= cyc_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign result_q    = res_q;
  assign cycle_count = cyc_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: expected writes and run outcomes are queued by a frame-level model
// and popped by negedge monitors as the DUT presents mem_we and done/error.
module tb_cpu_boot_loader;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clear = 1'b0;
  logic       cpu_halt = 1'b0;
  logic [7:0] cpu_result = 8'h00;
  logic       in_ready, mem_we, cpu_reset, done, error;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, result_q;
  logic [15:0] cycle_count;
  logic [1:0] err_code;

  cpu_boot_loader #(
    .ADDR_W (5), .DATA_W (8), .MAX_LEN (32), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_data (in_data),
    .in_ready (in_ready), .clear (clear), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .cpu_reset (cpu_reset), .cpu_halt (cpu_halt),
    .cpu_result (cpu_result), .result_q (result_q), .cycle_count (cycle_count),
    .done (done), .error (error), .err_code (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  typedef struct {
    bit         done;
    logic [1:0] code;
    logic [7:0] res;
    int         cc;
    int         runlen;
  } out_t;

  wr_t  wq[$];
  out_t oq[$];
  wr_t  mw;
  out_t mo;

  logic [7:0] db[0:39];
  int         halt_after = 1 << 30;
  int         ridx = 0;
  logic [7:0] last_res = 8'h00;
  int         last_cc = 0;
  int         run_len = 0;
  logic       done_p = 1'b0;
  logic       error_p = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CPU stand-in: raises HALT on its halt_after-th cycle out of reset.
  always @(negedge clk) begin
    if (cpu_reset !== 1'b0) begin
      ridx = 0;
      cpu_halt = 1'b0;
    end else begin
      if (ridx == halt_after) cpu_halt = 1'b1;
      ridx++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mw = wq.pop_front();
          check("wr_addr", mem_addr, mw.a);
          check("wr_data", mem_wdata, mw.d);
          check("wr_cycle", cyc, mw.c);
        end
      end
      if (cpu_reset === 1'b0) run_len++;
      if (done && error) check("done_error_exclusive", 1, 0);
      if ((done && !done_p) || (error && !error_p)) begin
        if (oq.size() == 0) check("unexpected_outcome", 1, 0);
        else begin
          mo = oq.pop_front();
          check("done", done, mo.done);
          check("error", error, !mo.done);
          check("err_code", err_code, mo.code);
          check("cpu_reset_parked", cpu_reset, 1);
          check("run_cycles", run_len, mo.runlen);
          if (mo.done) begin
            check("result_q", result_q, mo.res);
            check("cycle_count", cycle_count, mo.cc);
          end
        end
      end
      if (cpu_reset === 1'b1) run_len = 0;
      done_p = done;
      error_p = error;
    end else begin
      done_p = 1'b0;
      error_p = 1'b0;
      run_len = 0;
    end
  end

  function automatic out_t model(input int len, input logic [7:0] chk, input int h,
                                 input logic [7:0] res);
    out_t o;
    logic [7:0] x;
    o = '{done: 1'b0, code: 2'd0, res: res, cc: 0, runlen: 0};
    if (len == 0 || len > 32) begin
      o.code = 2'd1;
      return o;
    end
    x = 8'h00;
    for (int i = 0; i < len; i++) x = x ^ db[i];
    if (x != chk) o.code = 2'd2;
    else if (h < TO) begin
      o.done = 1'b1;
      o.cc = h;
      o.runlen = h + 1;
    end else begin
      o.code = 2'd3;
      o.runlen = TO;
    end
    return o;
  endfunction

  task automatic send(input logic [7:0] b, output bit acc, output int pc);
    acc = 1'b0;
    pc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      in_valid = 1'b1;
      in_data = b;
      #1;
      if (in_ready) begin
        acc = 1'b1;
        pc = cyc + 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int len, input logic [7:0] chk, input int h,
                           input logic [7:0] res, input bit gaps, input bit track);
    out_t o;
    bit acc;
    int pc;
    o = model(len, chk, h, res);
    halt_after = h;
    cpu_result = res;
    if (track) begin
      oq.push_back(o);
      if (o.done) begin
        last_res = o.res;
        last_cc = o.cc;
      end
    end
    send(8'(len), acc, pc);
    if (len == 0 || len > 32) return;
    for (int i = 0; i < len; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(db[i], acc, pc);
      if (acc) wq.push_back('{a: 5'(i), d: db[i], c: pc});
    end
    if (gaps) idle($urandom_range(0, 2));
    send(chk, acc, pc);
  endtask

  task automatic wait_outcome();
    for (int t = 0; t < TO + 100 && !(done || error); t++) @(negedge clk);
    if (!(done || error)) check("outcome_wait_timeout", 0, 1);
    in_valid = 1'b1;
    in_data = 8'h05;
    #1 check("ready_low_when_parked", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h03;
    #1 check("ready_low_on_clear", in_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_done", done, 0);
    check("clr_error", error, 0);
    check("clr_err_code", err_code, 0);
    check("clr_cpu_reset", cpu_reset, 1);
    check("clr_in_ready", in_ready, 1);
    check("clr_result_kept", result_q, last_res);
    check("clr_count_kept", cycle_count, last_cc);
  endtask

  task automatic check_reset_vals();
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_result_q", result_q, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit acc;
    int pc;
    int len;
    logic [7:0] x;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);

    // Directed load-and-run example.
    db[0] = 8'h21; db[1] = 8'h42; db[2] = 8'hE0;
    run_frame(3, 8'h83, 7, 8'h05, 1'b0, 1'b1);
    check("cpu_released_after_chk", cpu_reset, 0);
    wait_outcome();
    do_clear();

    run_frame(0, 8'h00, 7, 8'h00, 1'b0, 1'b1);
    wait_outcome();
    do_clear();
    run_frame(33, 8'h00, 7, 8'h00, 1'b0, 1'b1);
    wait_outcome();
    do_clear();

    db[0] = 8'h10; db[1] = 8'h01;
    run_frame(2, 8'h00, 3, 8'h77, 1'b0, 1'b1);
    wait_outcome();
    do_clear();

    db[0] = 8'h3C;
    run_frame(1, 8'h3C, 1 << 20, 8'h11, 1'b0, 1'b1);
    wait_outcome();
    do_clear();
    run_frame(1, 8'h3C, TO - 1, 8'hA5, 1'b0, 1'b1);
    wait_outcome();
    do_clear();

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 9) == 0)
        len = ($urandom_range(0, 1) == 0) ? 0 : 33 + $urandom_range(0, 222);
      else
        len = $urandom_range(1, 32);
      x = 8'h00;
      for (int i = 0; i < 32; i++) begin
        db[i] = 8'($urandom);
        if (i < len) x = x ^ db[i];
      end
      if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
      run_frame(len, x, $urandom_range(0, 40), 8'($urandom), 1'b1, 1'b1);
      wait_outcome();
      do_clear();
    end

    // Stall mid-frame, then clear together with a valid byte.
    send(8'd4, acc, pc);
    send(8'hAA, acc, pc);
    if (acc) wq.push_back('{a: 5'd0, d: 8'hAA, c: pc});
    send(8'hBB, acc, pc);
    if (acc) wq.push_back('{a: 5'd1, d: 8'hBB, c: pc});
    idle(3);
    do_clear();
    db[0] = 8'h44;
    run_frame(1, 8'h44, 2, 8'h9C, 1'b0, 1'b1);
    wait_outcome();
    do_clear();

    // Reset while the CPU is running.
    db[0] = 8'h01; db[1] = 8'h02; db[2] = 8'h04;
    run_frame(3, 8'h07, 1 << 20, 8'h00, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("cpu_running_before_reset", cpu_reset, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res = 8'h00;
    last_cc = 0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);

    check("wr_queue_empty", wq.size(), 0);
    check("out_queue_empty", oq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
Upstream stage of the 8-bit RISC CPU. It receives a program as a byte stream over a valid/ready handshake and writes it into the CPU's 32x8 instruction memory. It checks a trailing XOR checksum, then releases the CPU from reset. It watches the HALT output, captures the result and cycle count, and then parks the CPU back in reset.

Parameters:
ADDR_W, 5, instruction-memory address width (32 words; matches the 5-bit PC)
DATA_W, 8, instruction/result width (3-bit opcode + 5-bit operand)
MAX_LEN, 32, maximum program length in words
TIMEOUT, 1000, maximum CPU run cycles before a watchdog error (must be < 2^16)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream byte valid
in_data  in  DATA_W  upstream byte
in_ready  out  1  loader can accept a byte (combinational)
clear  in  1  one-cycle pulse: abort and return to S_LEN
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_reset  out  1  reset to the CPU (active-high)
cpu_halt  in  1  CPU HALT
cpu_result  in  DATA_W  CPU result bus
result_q  out  DATA_W  result captured at HALT
cycle_count  out  16  CPU run cycles, captured at HALT
done  out  1  program ran to HALT
error  out  1  load or run failure
err_code  out  2  1 = bad length, 2 = checksum mismatch, 3 = timeout; 0 = none

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Values after reset:
  - state = S_LEN
  - mem_we, mem_addr, mem_wdata = 0
  - cpu_reset = 1
  - result_q, cycle_count, done, error, err_code = 0
  - instruction-memory contents are not touched
- Handshake: a byte is accepted when in_valid && in_ready on a rising edge.
  - in_ready = (state is S_LEN, S_DATA or S_CHECK) && !clear.
  - in_valid while in_ready = 0 is ignored. No byte is lost or duplicated.
- Frame format: LEN byte, then LEN instruction bytes, then CHK byte. CHK = XOR of all instruction bytes.
- S_LEN:
  - Accepted byte of 0 or > MAX_LEN -> S_ERR, err_code = 1.
  - Otherwise latch len, set wr_ptr = 0, csum = 0 -> S_DATA.
- S_DATA, on each accept:
  - Next cycle: mem_we = 1 for exactly one cycle, mem_addr = wr_ptr, mem_wdata = byte.
  - csum ^= byte; wr_ptr++.
  - After the len-th byte -> S_CHECK.
  - Back-to-back accepts give back-to-back single-cycle writes.
  - LEN = 32: wr_ptr wraps to 0 after the last write; this is harmless because the state leaves S_DATA.
- S_CHECK, on accept:
  - byte == csum -> S_RUN. cpu_reset goes to 0 on the edge entering S_RUN. The run counter clears to 0.
  - Otherwise -> S_ERR, err_code = 2.
- S_RUN:
  - cpu_reset = 0; counter increments every cycle.
  - cpu_halt = 1: result_q <= cpu_result, cycle_count <= counter, done <= 1, cpu_reset <= 1 -> S_HALTED.
  - Counter reaches TIMEOUT-1 without halt: cpu_reset <= 1, error <= 1, err_code = 3 -> S_ERR.
  - Halt and timeout in the same cycle: halt wins.
- S_HALTED / S_ERR: cpu_reset = 1, in_ready = 0. The state holds until clear.
- clear in any state:
  - next state S_LEN, cpu_reset = 1
  - done, error, err_code cleared
  - result_q and cycle_count kept until the next HALT
  - clear takes priority over a simultaneous byte accept, halt or timeout
- reset mid-load or mid-run: the full reset values above; partially written memory is left as is.
- error and done are never 1 at the same time.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W / DATA_W defaults
  - the state encoding S_LEN, S_DATA, S_CHECK, S_RUN, S_HALTED, S_ERR
  - the error codes ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT
- Single module. The run watchdog counter may be split out as cpu_run_watchdog (count, saturate, timeout flag); no other sub-module is warranted.

Test Plan:
- Load LEN=3, bytes 0x21,0x42,0xE0, CHK=0x83, CPU halts 7 cycles after release with result 0x05 -> writes at addr 0,1,2 one cycle after each accept; cpu_reset falls after CHK; result_q=0x05, cycle_count=7, done=1, cpu_reset=1.
- LEN=0, then LEN=33 after clear -> error=1, err_code=1 each time; no mem_we; in_ready=0 until clear.
- LEN=2, 0x10,0x01, CHK=0x00 -> two writes, error=1, err_code=2, cpu_reset stays 1.
- Valid load, CPU never halts -> after TIMEOUT cycles error=1, err_code=3, cpu_reset=1; halt and timeout in the same cycle gives done=1 and error=0.
- Stall in_valid mid-frame, then assert clear together with in_valid, then reset during S_RUN -> no byte accepted on the clear cycle; state back to S_LEN; after reset all outputs return to reset values and cpu_reset=1.
